alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; multiple of SLICE.
REQ-002 Parameter SLICE, default 4, bits processed per cycle.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand/op request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  operation code: 000 NOT A, 001 AND, 010 OR, 011 XOR, 100 ADD, 101 SUB (A-B), 110 NEG A, 111 PASS A.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; ignored for NOT, NEG, PASS.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flags  output  4  {N, Z, C, V}: negative, zero, carry, signed overflow.

Function
REQ-014 FSM states IDLE, BUSY, DONE; IDLE -> BUSY on in_valid&&in_ready; BUSY -> DONE after last slice; DONE -> IDLE on out_ready.
REQ-015 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 On accept: a, b, op latched; slice counter = 0; carry register = 1 for SUB/NEG, else 0.
REQ-017 Each BUSY cycle processes slice k (bits k*SLICE+SLICE-1..k*SLICE) and writes it into the result register; counter increments.
REQ-018 Latency: accept at edge N -> out_valid high after edge N+WIDTH/SLICE (8 for defaults).
REQ-019 SUB computes A + ~B + 1; NEG computes 0 + ~A + 1; ADD computes A + B; carry chained between slices via carry register.
REQ-020 C = carry out of MSB slice for ADD/SUB/NEG (SUB: C=1 means no borrow); C = 0 for logical ops and PASS.
REQ-021 V = signed overflow from MSB slice (carry-in XOR carry-out of bit WIDTH-1) for ADD/SUB/NEG; V = 0 otherwise.
REQ-022 N = result[WIDTH-1]; Z = 1 iff result == 0; computed when entering DONE.
REQ-023 result and flags held stable throughout DONE regardless of a, b, op, in_valid changes.
REQ-024 out_ready while not in DONE: ignored; in_valid while not IDLE: ignored, no request lost silently (in_ready low).
REQ-025 DONE with out_ready: next state IDLE, in_ready asserted the following cycle (no same-cycle overlap).

Reset
REQ-026 rst_n low at a rising edge: state IDLE, counter 0, carry 0, result 0, flags 0, out_valid 0, in_ready 1 after that edge.
REQ-027 Reset asserted during BUSY or DONE aborts the operation; no result is produced.

Structure
REQ-028 Shared package alu_pkg holds the op-code enum/constants and default WIDTH/SLICE constants.
REQ-029 One combinational sub-module alu_slice: SLICE-bit slice taking op, a slice, b slice, carry-in; producing result slice, carry-out, and MSB carry-in for overflow.

Verification
REQ-030 NOT a=0x0000FFFF -> result 0xFFFF0000, flags N=1 Z=0 C=0 V=0, out_valid exactly 8 cycles after accept.
REQ-031 ADD a=0xFFFFFFFF b=0x00000001 -> result 0x00000000, Z=1 C=1 V=0 N=0.
REQ-032 SUB a=0x80000000 b=0x00000001 -> result 0x7FFFFFFF, V=1 C=1 N=0.
REQ-033 NEG a=0x80000000 -> result 0x80000000, V=1 N=1; NEG a=0 -> result 0, Z=1 C=1.
REQ-034 Backpressure: out_ready low 5 cycles in DONE while a/b/op toggle -> result/flags unchanged, in_ready low; out_ready high -> IDLE next cycle.
REQ-035 rst_n low at BUSY cycle 3 -> out_valid never asserts, in_ready=1 after reset edge; next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial (slice-serial) ALU.
//   - Default operand width and slice width.
//   - Op-code enum and the controller state enum.
//   - Helpers that classify op-codes for carry seeding and flag generation.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SLICE = 4;

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_NEG  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG);
  endfunction

  // SUB and NEG are done as x + ~y + 1, so the chain starts with carry 1.
  function automatic logic carry_init(alu_op_e op);
    return (op == OP_SUB) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice.
// Ports:
//   op       : operation code
//   a_s, b_s : operand slices
//   c_in     : carry into the slice (from the carry register)
//   r_s      : result slice
//   c_out    : carry out of the slice (0 for non-arithmetic ops)
//   msb_c_in : carry into the top bit of the slice, used for signed overflow
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = ALU_SLICE
) (
  input  alu_op_e          op,
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             c_in,
  output logic [SLICE-1:0] r_s,
  output logic             c_out,
  output logic             msb_c_in
);

  logic [SLICE-1:0] x;
  logic [SLICE-1:0] y;
  logic [SLICE:0]   sum;

  always_comb begin
    x = '0;
    y = '0;
    case (op)
      OP_ADD: begin x = a_s; y = b_s;  end
      OP_SUB: begin x = a_s; y = ~b_s; end
      OP_NEG: begin x = '0;  y = ~a_s; end
      default: ;
    endcase

    sum = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c_in};

    case (op)
      OP_NOT:  r_s = ~a_s;
      OP_AND:  r_s = a_s & b_s;
      OP_OR:   r_s = a_s | b_s;
      OP_XOR:  r_s = a_s ^ b_s;
      OP_PASS: r_s = a_s;
      default: r_s = sum[SLICE-1:0];
    endcase

    c_out    = is_arith(op) & sum[SLICE];
    // Sum bit = x ^ y ^ carry-in, so the carry into the top bit falls out directly.
    msb_c_in = x[SLICE-1] ^ y[SLICE-1] ^ sum[SLICE-1];
  end

endmodule

// File: rtl/alu_seq.sv
// Slice-serial ALU: accepts one request, processes WIDTH/SLICE slices (one
// per cycle, LSB first), then presents result and {N,Z,C,V} until consumed.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : request handshake (op, a, b)
//   out_valid / out_ready: result handshake (result, flags)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; in_ready high
// ST_BUSY | one slice processed per cycle, carry chained via carry_q
// ST_DONE | result/flags held; out_valid high until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SLICE = ALU_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  alu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_e          op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [31:0]      base;
  logic [SLICE-1:0] r_s;
  logic             c_out;
  logic             msb_c_in;

  assign base = 32'(cnt_q) * 32'(SLICE);

  alu_slice #(.SLICE(SLICE)) u_slice (
    .op       (op_q),
    .a_s      (a_q[base +: SLICE]),
    .b_s      (b_q[base +: SLICE]),
    .c_in     (carry_q),
    .r_s      (r_s),
    .c_out    (c_out),
    .msb_c_in (msb_c_in)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          a_d     = a;
          b_d     = b;
          op_d    = alu_op_e'(op);
          cnt_d   = '0;
          carry_d = carry_init(alu_op_e'(op));
        end
      end
      ST_BUSY: begin
        result_d[base +: SLICE] = r_s;
        carry_d = c_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSL - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          // Flags are taken from the fully assembled result including this last slice.
          flags_d = {result_d[WIDTH-1],
                     (result_d == '0),
                     c_out,
                     is_arith(op_q) & (msb_c_in ^ c_out)};
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOT;
      carry_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  vec_t vecs[14];
  exp_t exp_q[$];

  alu_seq #(.WIDTH(32), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // Whole-word reference model, independent of the slice structure.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (o)
      3'd0: r = ~x;
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'd5: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'd6: begin
        s = {1'b0, ~x} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (x == 32'h8000_0000);
      end
      default: r = x;
    endcase
    e.r = r;
    e.f = {r[31], (r == 32'd0), c, v};
    return e;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [3:0] ef, input int hold);
    exp_t e;
    int k;
    int lat;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk("in_ready_before_req", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    k = cyc;
    e.r = er; e.f = ef;
    exp_q.push_back(e);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - k;
        break;
      end
      if (in_ready) begin
        chk("in_ready_low_busy", in_ready, 0);
      end
    end
    chk("latency", lat, 8);
    if (lat < 0) begin
      void'(exp_q.pop_front());
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, exp_q[0].r);
      chk("hold_flags", flags, exp_q[0].f);
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    chk("out_valid", out_valid, 1);
    chk("result", result, e.r);
    chk("flags", flags, e.f);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    exp_t m;
    int seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    //          op    a             b             result        {N,Z,C,V}
    vecs[0]  = '{3'd0, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 4'b1000};
    vecs[1]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    vecs[2]  = '{3'd5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    vecs[3]  = '{3'd6, 32'h80000000, 32'h12345678, 32'h80000000, 4'b1001};
    vecs[4]  = '{3'd6, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0110};
    vecs[5]  = '{3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000};
    vecs[6]  = '{3'd2, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
    vecs[7]  = '{3'd3, 32'h12345678, 32'h12345678, 32'h00000000, 4'b0100};
    vecs[8]  = '{3'd7, 32'h7FFFFFFF, 32'hAAAAAAAA, 32'h7FFFFFFF, 4'b0000};
    vecs[9]  = '{3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    vecs[10] = '{3'd5, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b1000};
    vecs[11] = '{3'd5, 32'h00000007, 32'h00000005, 32'h00000002, 4'b0010};
    vecs[12] = '{3'd5, 32'h00000003, 32'h00000003, 32'h00000000, 4'b0110};
    vecs[13] = '{3'd4, 32'h0000000F, 32'h00000001, 32'h00000010, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", flags, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f, 0);

    // Backpressure: five DONE cycles with out_ready low and inputs toggling.
    run_op(3'd4, 32'h89ABCDEF, 32'h76543210, 32'hFFFFFFFF, 4'b1000, 5);

    // Reset during BUSY: edges N+1, N+2 process slices, edge N+3 sees rst_n low.
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    op = 3'd4; a = 32'h11111111; b = 32'h22222222; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", flags, 4'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    run_op(3'd5, 32'h00000010, 32'h00000001, 32'h0000000F, 4'b0010, 1);

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ~ra;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m.r, m.f, i % 3);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
